// File: rtl/lsu_pkg.sv
// ============================================================================
// Module      : lsu_pkg
// Description : Shared types, Funct3 encodings and store formatting helpers
//               for the load/store unit.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    // Access size is carried by Funct3[1:0]; 2'b11 falls through to word.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            2'b00:   is_misaligned = 1'b0;
            2'b01:   is_misaligned = offset[0];
            default: is_misaligned = (offset != 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            2'b00:   store_be = 4'b0001 << offset;
            2'b01:   store_be = 4'b0011 << offset;
            default: store_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            2'b00:   store_data = {4{wdata[7:0]}};
            2'b01:   store_data = {2{wdata[15:0]}};
            default: store_data = wdata;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/load_extend.sv
// ============================================================================
// Module      : load_extend
// Description : Selects the addressed lane of a bus read word and sign- or
//               zero-extends it according to Funct3.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_offset)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
    end

    assign w_half = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        case (i_funct3)
            LB:      o_data = {{24{w_byte[7]}}, w_byte};
            LH:      o_data = {{16{w_half[15]}}, w_half};
            LBU:     o_data = {24'd0, w_byte};
            LHU:     o_data = {16'd0, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module      : load_store_unit
// Description : Single-outstanding load/store unit with a req/ack data bus.
//               Optional bus timeout enabled by defining LSU_TIMEOUT_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Mem_read,
    input  logic        Mem_write,
    input  logic [2:0]  Funct3,
    input  logic [31:0] ALU_result,
    input  logic [31:0] Write_data,
    output logic [31:0] Read_data,
    output logic        Stall,
    output logic        Misaligned,
    output logic        Timeout,
    output logic        Bus_req,
    output logic        Bus_we,
    output logic [31:0] Bus_addr,
    output logic [31:0] Bus_wdata,
    output logic [3:0]  Bus_be,
    input  logic        Bus_ack,
    input  logic [31:0] Bus_rdata
);

    lsu_state_t  r_state;
    lsu_state_t  w_next_state;
    logic [1:0]  r_offset;
    logic [2:0]  r_funct3;
    logic        r_is_load;
    logic        w_access;
    logic        w_misaligned;
    logic        w_timeout_hit;
    logic [31:0] w_load_data;

    assign w_access     = Mem_read | Mem_write;
    assign w_misaligned = is_misaligned(Funct3[1:0], ALU_result[1:0]);

    load_extend u_load_extend (
        .i_rdata  (Bus_rdata),
        .i_offset (r_offset),
        .i_funct3 (r_funct3),
        .o_data   (w_load_data)
    );

    always_comb begin
        w_next_state = r_state;
        Stall        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_access && !w_misaligned) begin
                    w_next_state = REQ;
                    Stall        = 1'b1;
                end
            end
            REQ: begin
                Stall = 1'b1;
                if (Bus_ack || w_timeout_hit) begin
                    w_next_state = DONE;
                end
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            Read_data  <= '0;
            Bus_req    <= 1'b0;
            Bus_we     <= 1'b0;
            Bus_addr   <= '0;
            Bus_wdata  <= '0;
            Bus_be     <= '0;
            Misaligned <= 1'b0;
            r_offset   <= '0;
            r_funct3   <= '0;
            r_is_load  <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            Misaligned <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_access) begin
                        if (w_misaligned) begin
                            Misaligned <= 1'b1;
                        end else begin
                            // Mem_write wins when both strobes are present.
                            Bus_req   <= 1'b1;
                            Bus_we    <= Mem_write;
                            Bus_addr  <= {ALU_result[31:2], 2'b00};
                            Bus_wdata <= Mem_write ? store_data(Funct3[1:0], Write_data) : '0;
                            Bus_be    <= Mem_write ? store_be(Funct3[1:0], ALU_result[1:0]) : 4'b1111;
                            r_offset  <= ALU_result[1:0];
                            r_funct3  <= Funct3;
                            r_is_load <= !Mem_write;
                        end
                    end
                end
                REQ: begin
                    if (Bus_ack) begin
                        Bus_req <= 1'b0;
                        if (r_is_load) begin
                            Read_data <= w_load_data;
                        end
                    end else if (w_timeout_hit) begin
                        Bus_req <= 1'b0;
                        if (r_is_load) begin
                            Read_data <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef LSU_TIMEOUT_EN
    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_CNT_W-1:0] r_req_cnt;
    logic               r_timeout;

    // Counter holds the number of REQ cycles already spent before this one.
    assign w_timeout_hit = (r_state == REQ) && (r_req_cnt == c_CNT_W'(TIMEOUT_CYCLES - 1));
    assign Timeout       = r_timeout;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_req_cnt <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_timeout_hit && !Bus_ack;
            r_req_cnt <= (r_state == REQ) ? r_req_cnt + 1'b1 : '0;
        end
    end
`else
    logic w_unused_timeout;

    assign w_timeout_hit    = 1'b0;
    assign Timeout          = 1'b0;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module      : tb_load_store_unit
// Description : Scoreboard bench for load_store_unit with a behavioural
//               reference model and randomized accesses.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        Mem_read, Mem_write;
    logic [2:0]  Funct3;
    logic [31:0] ALU_result, Write_data, Read_data;
    logic        Stall, Misaligned, Timeout;
    logic        Bus_req, Bus_we, Bus_ack;
    logic [31:0] Bus_addr, Bus_wdata, Bus_rdata;
    logic [3:0]  Bus_be;

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .Mem_read(Mem_read), .Mem_write(Mem_write),
        .Funct3(Funct3), .ALU_result(ALU_result), .Write_data(Write_data),
        .Read_data(Read_data), .Stall(Stall), .Misaligned(Misaligned),
        .Timeout(Timeout), .Bus_req(Bus_req), .Bus_we(Bus_we),
        .Bus_addr(Bus_addr), .Bus_wdata(Bus_wdata), .Bus_be(Bus_be),
        .Bus_ack(Bus_ack), .Bus_rdata(Bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [3:0]  be;
    } bus_t;

    typedef struct {
        logic [31:0] rdata;
        logic        timeout;
    } rd_t;

    bus_t        bus_q[$];
    rd_t         rd_q[$];
    logic [31:0] mis_q[$];
    bus_t        cur;
    logic        prev_req = 1'b0;
    logic [31:0] rd_model = 32'd0;
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got event expected none", name);
    endtask

    // Reference model: lane pick by byte arithmetic, then extension.
    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        logic [31:0] v;
        v = rdata >> (8 * addr[1:0]);
        case (f3)
            3'b000:  return v[7]  ? ((v & 32'hFF)   | 32'hFFFFFF00) : (v & 32'hFF);
            3'b001:  return v[15] ? ((v & 32'hFFFF) | 32'hFFFF0000) : (v & 32'hFFFF);
            3'b100:  return v & 32'hFF;
            3'b101:  return v & 32'hFFFF;
            default: return rdata;
        endcase
    endfunction

    function automatic int size_of(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents a bus request,
    // a completion (Bus_req falling) or a misalignment pulse.
    always @(negedge clk) begin
        if (Bus_req === 1'b1 && !prev_req) begin
            if (bus_q.size() == 0) begin
                fail_now("bus_req_unexpected");
            end else begin
                check("bus_addr", Bus_addr, bus_q[0].addr);
                check("bus_we", Bus_we, bus_q[0].we);
                check("bus_be", Bus_be, bus_q[0].be);
                if (bus_q[0].we) check("bus_wdata", Bus_wdata, bus_q[0].wdata);
                cur <= bus_q[0];
                bus_q.pop_front();
            end
        end else if (Bus_req === 1'b1 && prev_req) begin
            check("bus_hold", {Bus_addr, Bus_we, Bus_be}, {cur.addr, cur.we, cur.be});
            if (cur.we) check("bus_wdata_hold", Bus_wdata, cur.wdata);
        end
        if (Bus_req !== 1'b1 && prev_req) begin
            if (rd_q.size() == 0) begin
                fail_now("completion_unexpected");
            end else begin
                check("read_data", Read_data, rd_q[0].rdata);
                check("timeout", Timeout, rd_q[0].timeout);
                rd_q.pop_front();
            end
        end
        if (Misaligned === 1'b1) begin
            if (mis_q.size() == 0) begin
                fail_now("misaligned_unexpected");
            end else begin
                check("misaligned_read_data", Read_data, mis_q[0]);
                mis_q.pop_front();
            end
        end
        prev_req <= (Bus_req === 1'b1);
    end

    // delay = cycles of Bus_ack wait beyond the earliest; negative = never ack.
    task automatic access(input bit is_store, input bit also_read, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int delay);
        int   off, sz, stalls, exp_stalls;
        bit   mis;
        bus_t b;
        rd_t  r;
        off = int'(addr[1:0]);
        sz  = size_of(f3);
        mis = (sz == 2 && (off % 2) != 0) || (sz == 4 && off != 0);
        @(posedge clk);
        #1;
        Mem_write  = is_store;
        Mem_read   = !is_store || also_read;
        Funct3     = f3;
        ALU_result = addr;
        Write_data = wdata;
        Bus_ack    = 1'b0;
        Bus_rdata  = $urandom;
        if (mis) begin
            mis_q.push_back(rd_model);
            @(negedge clk);
            check("stall_misaligned", Stall, 1'b0);
            @(posedge clk);
            #1;
            Mem_read  = 1'b0;
            Mem_write = 1'b0;
            return;
        end
        b.addr = addr - 32'(off);
        b.we   = is_store;
        if (is_store) begin
            b.be    = (sz == 1) ? 4'(1 << off) : (sz == 2) ? 4'(3 << off) : 4'hF;
            b.wdata = (sz == 1) ? (wdata & 32'hFF) * 32'h01010101 :
                      (sz == 2) ? (wdata & 32'hFFFF) * 32'h00010001 : wdata;
        end else begin
            b.be    = 4'hF;
            b.wdata = 32'd0;
            rd_model = (delay < 0) ? 32'd0 : model_load(f3, addr, rdata);
        end
        bus_q.push_back(b);
        r.rdata   = rd_model;
        r.timeout = (delay < 0);
        rd_q.push_back(r);
        exp_stalls = (delay < 0) ? 1 + TO : 2 + delay;
        stalls = 0;
        for (int c = 0; c < 64; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
                Bus_ack   = (c == 1 + delay);
                Bus_rdata = Bus_ack ? rdata : $urandom;
            end
            @(negedge clk);
            if (Stall !== 1'b1) break;
            stalls++;
        end
        check("stall_cycles", stalls, exp_stalls);
        @(posedge clk);
        #1;
        Mem_read  = 1'b0;
        Mem_write = 1'b0;
        Bus_ack   = 1'b0;
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            Bus_ack   = 1'($urandom_range(0, 1));
            Bus_rdata = $urandom;
        end
        @(posedge clk);
        #1;
        Bus_ack = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; Mem_read = 1'b0; Mem_write = 1'b0; Funct3 = 3'd0;
        ALU_result = 32'd0; Write_data = 32'd0; Bus_ack = 1'b0; Bus_rdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset_bus", {Bus_req, Bus_we, Bus_addr, Bus_wdata, Bus_be}, 96'd0);
        check("reset_read_data", Read_data, 32'd0);
        check("reset_pulses", {Misaligned, Timeout, Stall}, 3'b000);

        access(1'b0, 1'b0, LW, 32'h100, 32'd0, 32'hDEADBEEF, 0);
        check("lw_0x100", Read_data, 32'hDEADBEEF);
        access(1'b0, 1'b0, LB, 32'h103, 32'd0, 32'h80FF0000, 2);
        check("lb_0x103", Read_data, 32'hFFFFFF80);
        access(1'b0, 1'b0, LBU, 32'h103, 32'd0, 32'h80FF0000, 2);
        check("lbu_0x103", Read_data, 32'h00000080);
        access(1'b1, 1'b0, SH, 32'h102, 32'h1234ABCD, 32'd0, 1);
        check("sh_keeps_read_data", Read_data, 32'h00000080);
        access(1'b0, 1'b0, LW, 32'h101, 32'd0, 32'd0, 0);
        check("lw_misaligned_keeps", Read_data, 32'h00000080);
        idle_gap(3);

        // Reset while REQ is outstanding, with a stray ack afterwards.
        @(posedge clk);
        #1;
        Mem_read = 1'b1; Funct3 = LW; ALU_result = 32'h200;
        bus_q.push_back('{addr: 32'h200, wdata: 32'd0, we: 1'b0, be: 4'hF});
        rd_q.push_back('{rdata: 32'd0, timeout: 1'b0});
        @(posedge clk);
        #1;
        reset = 1'b1; Mem_read = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        rd_model = 32'd0;
        @(negedge clk);
        check("reset_in_req", {Bus_req, Stall, Read_data}, 34'd0);
        @(posedge clk);
        #1;
        Bus_ack = 1'b1; Bus_rdata = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        Bus_ack = 1'b0;
        @(negedge clk);
        check("late_ack_ignored", {Bus_req, Read_data}, 33'd0);

        for (int n = 0; n < 150; n++) begin
            bit          st;
            logic [2:0]  f3;
            st = 1'($urandom_range(0, 2) == 0);
            f3 = st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            access(st, 1'($urandom_range(0, 1)), f3, $urandom, $urandom, $urandom,
                   int'($urandom_range(0, 3)));
            if ($urandom_range(0, 2) == 0) idle_gap(int'($urandom_range(1, 3)));
        end

`ifdef LSU_TIMEOUT_EN
        access(1'b0, 1'b0, LW, 32'h300, 32'd0, 32'd0, -1);
        check("timeout_read_data", Read_data, 32'd0);
`endif

        idle_gap(2);
        check("bus_q_drained", bus_q.size(), 0);
        check("rd_q_drained", rd_q.size(), 0);
        check("mis_q_drained", mis_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum number of REQ cycles without Bus_ack; used only when LSU_TIMEOUT_EN is defined.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high. Ports are clk and reset.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 Mem_read  in  1  execute a load this cycle.
REQ-006 Mem_write  in  1  execute a store this cycle; it has priority over Mem_read.
REQ-007 Funct3  in  3  access size and sign.
REQ-008 ALU_result  in  32  byte address.
REQ-009 Write_data  in  32  store data, LSB-aligned.
REQ-010 Read_data  out  32  extended load result, feeding the writeback result select.
REQ-011 Stall  out  1  holds the pipeline while an access is in flight.
REQ-012 Misaligned  out  1  one-cycle fault pulse.
REQ-013 Timeout  out  1  one-cycle bus-timeout pulse.
REQ-014 Bus_req/Bus_we  out  1 each; Bus_addr  out  32; Bus_wdata  out  32; Bus_be  out  4; Bus_ack  in  1; Bus_rdata  in  32.

Function
REQ-015 The FSM SHALL have three states:
- IDLE -> REQ on an aligned access.
- REQ -> DONE on Bus_ack, or on timeout.
- DONE -> IDLE unconditionally.
REQ-016 Stall SHALL be combinational: 1 in IDLE when an aligned access is present, 1 in REQ, and 0 in DONE and otherwise.
REQ-017 Bus_req, Bus_we, Bus_addr, Bus_wdata and Bus_be SHALL be registered on the IDLE->REQ edge and held stable while Bus_req=1.
REQ-018 Bus_addr SHALL be {ALU_result[31:2],2'b00}.
REQ-019 Store byte enables and data:
- SB: Bus_be = 4'b0001<<addr[1:0], data byte replicated to all lanes.
- SH: Bus_be = 4'b0011<<addr[1:0], halfword replicated to both halves.
- SW: Bus_be = 4'b1111.
REQ-020 Loads SHALL drive Bus_be = 4'b1111.
REQ-021 On the Bus_ack cycle, Bus_rdata SHALL be lane-selected by addr[1:0] and extended: 000 LB sign, 001 LH sign, 010 LW, 100 LBU zero, 101 LHU zero. Funct3 011/110/111 SHALL be treated as word access.
REQ-022 Read_data SHALL update on the edge leaving REQ for loads only, and hold its value otherwise.
REQ-023 Latency: access presented at cycle 0, earliest Bus_ack at cycle 1, Read_data valid and Stall=0 at cycle 2; each extra wait cycle adds one cycle.
REQ-024 A halfword access with addr[0]=1, or a word access with addr[1:0]!=0, SHALL pulse Misaligned for one cycle, issue no bus access, keep Stall=0 and leave Read_data unchanged.
REQ-025 Bus_ack outside REQ SHALL be ignored.
REQ-026 Bus_req SHALL drop on the edge that samples Bus_ack.

Reset
REQ-027 Reset SHALL set state=IDLE and set Read_data, Bus_req, Bus_we, Bus_addr, Bus_wdata, Bus_be, Misaligned and Timeout to 0.
REQ-028 Reset during REQ SHALL abandon the access: Bus_req=0 after the reset edge, and a later Bus_ack is ignored.

Configuration
REQ-029 When LSU_TIMEOUT_EN is defined:
- A REQ-cycle counter SHALL run.
- On reaching TIMEOUT_CYCLES, it SHALL drop Bus_req, pulse Timeout, load Read_data=0 (loads only) and enter DONE.
REQ-030 When LSU_TIMEOUT_EN is undefined, REQ SHALL wait indefinitely and Timeout SHALL be tied to 0.

Structure
REQ-031 Package lsu_pkg SHALL hold the state enum and the Funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW).
REQ-032 Lane select and extension SHALL be a combinational sub-module, load_extend.

Verification
REQ-033 LW at 0x100, Bus_rdata=0xDEADBEEF, Bus_ack at cycle 1 -> Bus_addr=0x100; Read_data=0xDEADBEEF and Stall=0 at cycle 2.
REQ-034 LB at 0x103 and LBU at 0x103, Bus_rdata=0x80FF_0000, each with a 3-cycle ack delay -> LB gives Read_data=0xFFFFFF80; LBU gives 0x00000080; Stall high for 4 cycles.
REQ-035 SH at 0x102, Write_data=0x1234ABCD -> Bus_be=4'b1100, Bus_wdata=0xABCDABCD, Bus_we=1; Read_data unchanged.
REQ-036 LW at 0x101 -> Misaligned pulse, Bus_req never asserted, Stall=0.
REQ-037 Reset asserted during REQ, then Bus_ack two cycles later -> Bus_req=0 after reset, state IDLE, Read_data=0.
REQ-038 With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, a load with no ack -> Timeout pulse after 4 REQ cycles, Read_data=0, Stall released next cycle.
